// File: rtl/sha_1_padder.sv
// SHA-1 message padder: packs 32-bit big-endian message words into 512-bit blocks,
//   appends the 0x80 pad byte, zero fill and the 64-bit bit length, drives each block to
//   the sha_1 core and returns the final digest with a one-cycle hash_valid strobe.
// Latency: after the last word, (16 - wcnt) pad cycles, 1 SEND cycle, core time, 1 DONE cycle.
// Backpressure: in_ready is high only in FILL; words offered elsewhere are held off, not dropped.
//
// Ports:
//   clk, rst                     clock (rising edge), asynchronous active-low reset
//   in_data/in_valid/in_ready    message word stream; first byte in [31:24]
//   in_last, in_bytes            final word marker, valid bytes in it (0 means 4)
//   blk_data, blk_index          block to the core (word i at [i*32 +: 32]), 1-based block number
//   blk_enable                   one-cycle start pulse to the core
//   core_hash, core_ready        core result and its one-cycle done pulse
//   hash, hash_valid             final digest {H0..H4} and its one-cycle update strobe
//   busy                         a message is in progress
module sha_1_padder (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [1:0]   in_bytes,
  output logic         in_ready,
  output logic [511:0] blk_data,
  output logic [63:0]  blk_index,
  output logic         blk_enable,
  input  logic [159:0] core_hash,
  input  logic         core_ready,
  output logic [159:0] hash,
  output logic         hash_valid,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_FILL,
    S_PAD,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [4:0]        wcnt_q;       // next free word slot, 0..16
  logic [15:0][31:0] buf_q;        // block under construction; word i at bits [i*32 +: 32]
  logic [63:0]       bitcnt_q;     // message length in bits
  logic [63:0]       index_q;      // blocks completed so far in this message
  logic [63:0]       blk_index_q;
  logic              more_q;       // another block follows the one in flight
  logic              len_pend_q;   // length did not fit: an extra pad-only block is needed
  logic              pad_pend_q;   // last word was full, the 0x80000000 word is still owed
  logic              len_hi_q;     // word 14 of this block already holds bitcnt[63:32]
  logic              in_ready_q;
  logic              blk_enable_q;
  logic [159:0]      hash_q;
  logic              hash_valid_q;

  logic [31:0]       last_word;
  logic [63:0]       bit_inc;
  logic              accept;

  assign accept     = in_valid & in_ready_q;
  assign in_ready   = in_ready_q;
  assign blk_data   = buf_q;
  assign blk_index  = blk_index_q;
  assign blk_enable = blk_enable_q;
  assign hash       = hash_q;
  assign hash_valid = hash_valid_q;
  assign busy       = !((state_q == S_FILL) && (wcnt_q == 5'd0));

  // Word actually stored and bits it contributes. A partial last word gets the pad
  // byte right after its valid bytes; stale bytes behind it are discarded.
  always_comb begin
    last_word = in_data;
    bit_inc   = 64'd32;
    if (in_last) begin
      case (in_bytes)
        2'd1: begin
          last_word = {in_data[31:24], 24'h80_0000};
          bit_inc   = 64'd8;
        end
        2'd2: begin
          last_word = {in_data[31:16], 16'h8000};
          bit_inc   = 64'd16;
        end
        2'd3: begin
          last_word = {in_data[31:8], 8'h80};
          bit_inc   = 64'd24;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FILL;
      wcnt_q       <= 5'd0;
      buf_q        <= '0;
      bitcnt_q     <= 64'd0;
      index_q      <= 64'd0;
      blk_index_q  <= 64'd0;
      more_q       <= 1'b0;
      len_pend_q   <= 1'b0;
      pad_pend_q   <= 1'b0;
      len_hi_q     <= 1'b0;
      in_ready_q   <= 1'b0;
      blk_enable_q <= 1'b0;
      hash_q       <= 160'd0;
      hash_valid_q <= 1'b0;
    end else begin
      blk_enable_q <= 1'b0;
      hash_valid_q <= 1'b0;
      case (state_q)
        S_FILL: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            buf_q[wcnt_q[3:0]] <= last_word;
            wcnt_q             <= wcnt_q + 5'd1;
            bitcnt_q           <= bitcnt_q + bit_inc;
            if (in_last) begin
              pad_pend_q <= (in_bytes == 2'd0);
              in_ready_q <= 1'b0;
              state_q    <= S_PAD;
            end else if (wcnt_q == 5'd15) begin
              more_q     <= 1'b1;
              in_ready_q <= 1'b0;
              state_q    <= S_SEND;
            end
          end
        end

        S_PAD: begin
          if (wcnt_q == 5'd16) begin
            // Block filled by the message itself; pad word and/or length go in the next one.
            more_q     <= 1'b1;
            len_pend_q <= 1'b1;
            state_q    <= S_SEND;
          end else if (pad_pend_q) begin
            buf_q[wcnt_q[3:0]] <= 32'h8000_0000;
            pad_pend_q         <= 1'b0;
            wcnt_q             <= wcnt_q + 5'd1;
          end else if (wcnt_q == 5'd14) begin
            buf_q[4'd14] <= bitcnt_q[63:32];
            len_hi_q     <= 1'b1;
            wcnt_q       <= 5'd15;
          end else if (wcnt_q == 5'd15) begin
            wcnt_q  <= 5'd16;
            state_q <= S_SEND;
            if (len_hi_q) begin
              buf_q[4'd15] <= bitcnt_q[31:0];
              more_q       <= 1'b0;
            end else begin
              // Pad byte sits in word 14: no room for the length here.
              buf_q[4'd15] <= 32'd0;
              more_q       <= 1'b1;
              len_pend_q   <= 1'b1;
            end
          end else begin
            buf_q[wcnt_q[3:0]] <= 32'd0;
            wcnt_q             <= wcnt_q + 5'd1;
          end
        end

        S_SEND: begin
          blk_enable_q <= 1'b1;
          blk_index_q  <= index_q + 64'd1;
          state_q      <= S_WAIT;
        end

        S_WAIT: begin
          if (core_ready) begin
            index_q  <= index_q + 64'd1;
            buf_q    <= '0;
            wcnt_q   <= 5'd0;
            len_hi_q <= 1'b0;
            if (!more_q) begin
              state_q <= S_DONE;
            end else if (len_pend_q) begin
              len_pend_q <= 1'b0;
              state_q    <= S_PAD;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= S_FILL;
            end
          end
        end

        S_DONE: begin
          hash_q       <= core_hash;
          hash_valid_q <= 1'b1;
          index_q      <= 64'd0;
          bitcnt_q     <= 64'd0;
          more_q       <= 1'b0;
          len_pend_q   <= 1'b0;
          pad_pend_q   <= 1'b0;
          len_hi_q     <= 1'b0;
          in_ready_q   <= 1'b1;
          state_q      <= S_FILL;
        end

        default: begin
          state_q <= S_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_1_padder.sv
// Bench for sha_1_padder: stands in for the sha_1 core with a behavioural SHA-1
//   compression, feeds messages with random gaps and compares every block and digest
//   against a byte-level padding model and known SHA-1 vectors.
module tb_sha_1_padder;

  typedef logic [7:0] bq_t[$];

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  in_data = 32'd0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic [1:0]   in_bytes = 2'd0;
  logic         in_ready;
  logic [511:0] blk_data;
  logic [63:0]  blk_index;
  logic         blk_enable;
  logic [159:0] core_hash;
  logic         core_ready;
  logic [159:0] hash;
  logic         hash_valid;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [159:0] IV      = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [159:0] DIG_ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] DIG_56  = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;
  localparam string        STR_56  = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

  sha_1_padder dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_bytes   (in_bytes),
    .in_ready   (in_ready),
    .blk_data   (blk_data),
    .blk_index  (blk_index),
    .blk_enable (blk_enable),
    .core_hash  (core_hash),
    .core_ready (core_ready),
    .hash       (hash),
    .hash_valid (hash_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference functions ----------------
  function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] w [0:79];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = blk[i*32 +: 32];
    for (int i = 16; i < 80; i++) begin
      t    = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  // Padded message at byte level: msg, 0x80, zeros up to 56 mod 64, 64-bit big-endian bit length.
  function automatic void model_blocks(input bq_t m, output logic [511:0] blks[$]);
    logic [7:0]  p[$];
    logic [63:0] bits;
    logic [511:0] blk;
    p    = m;
    bits = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[i*8 +: 8]);
    blks.delete();
    for (int kb = 0; kb < p.size() / 64; kb++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[(j/4)*32 + (3 - j%4)*8 +: 8] = p[kb*64 + j];
      blks.push_back(blk);
    end
  endfunction

  function automatic logic [159:0] model_digest(input logic [511:0] blks[$]);
    logic [159:0] h;
    h = IV;
    foreach (blks[i]) h = sha1_compress(h, blks[i]);
    return h;
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t rand_msg(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // ---------------- core stand-in and monitors ----------------
  logic [159:0] core_h;
  logic         core_rdy;
  logic         spur = 1'b0;
  int           core_cnt;
  logic [511:0] rec_data[$];
  logic [63:0]  rec_idx[$];
  logic [159:0] dig_q[$];

  assign core_hash  = core_h;
  assign core_ready = core_rdy | spur;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      core_h   = 160'd0;
      core_rdy = 1'b0;
      core_cnt = 0;
    end else begin
      core_rdy = 1'b0;
      if (blk_enable) begin
        core_h = sha1_compress((blk_index == 64'd1) ? IV : core_h, blk_data);
        rec_data.push_back(blk_data);
        rec_idx.push_back(blk_index);
        core_cnt = $urandom_range(6, 1);
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) core_rdy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && hash_valid) dig_q.push_back(hash);
  end

  // ---------------- stimulus ----------------
  task automatic clear_logs();
    rec_data.delete();
    rec_idx.delete();
    dig_q.delete();
  endtask

  task automatic send_msg(input bq_t m, input int gap_pct, input bit poke);
    int nw, i, guard;
    bit poked;
    logic [31:0] w;
    nw = (m.size() + 3) / 4;
    i = 0; guard = 0; poked = 0;
    while (i < nw && guard < 20000) begin
      @(negedge clk);
      guard++;
      spur = 1'b0;
      if (poke && !poked && i == 2) begin
        spur  = 1'b1;
        poked = 1;
      end
      if (blk_enable) begin
        n_tests++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL inrdy_send: in_ready=%b while block in flight, want 0", in_ready);
        end
      end
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        for (int j = 0; j < 4; j++)
          w[31 - 8*j -: 8] = (4*i + j < m.size()) ? m[4*i + j] : 8'($urandom);
        in_valid = 1'b1;
        in_data  = w;
        in_last  = (i == nw - 1);
        in_bytes = in_last ? 2'(m.size() % 4) : 2'($urandom);
        if (in_ready) i++;
      end
    end
    n_tests++;
    if (i < nw) begin
      n_fail++;
      $display("FAIL send_timeout: %0d of %0d words accepted", i, nw);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    spur     = 1'b0;
  endtask

  task automatic wait_digest(input int n);
    int c;
    c = 0;
    while (dig_q.size() < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (dig_q.size() < n) begin
      n_fail++;
      $display("FAIL digest_timeout: got %0d digests, want %0d", dig_q.size(), n);
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests += 7;
    if (in_ready !== 1'b0)        begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    if (blk_enable !== 1'b0)      begin n_fail++; $display("FAIL rst_blk_enable: got %b want 0", blk_enable); end
    if (blk_data !== 512'd0)      begin n_fail++; $display("FAIL rst_blk_data: got %h want 0", blk_data); end
    if (blk_index !== 64'd0)      begin n_fail++; $display("FAIL rst_blk_index: got %h want 0", blk_index); end
    if (hash !== 160'd0)          begin n_fail++; $display("FAIL rst_hash: got %h want 0", hash); end
    if (hash_valid !== 1'b0)      begin n_fail++; $display("FAIL rst_hash_valid: got %b want 0", hash_valid); end
    if (busy !== 1'b0)            begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests += 2;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_abc();
    logic [511:0] exp;
    clear_logs();
    send_msg(str2q("abc"), 0, 0);
    wait_digest(1);
    exp = '0;
    exp[31:0]    = 32'h61626380;
    exp[511:480] = 32'h00000018;
    n_tests += 2;
    if (rec_data.size() != 1) begin n_fail++; $display("FAIL abc_nblk: got %0d want 1", rec_data.size()); end
    if (dig_q.size() != 1)    begin n_fail++; $display("FAIL abc_npulse: got %0d want 1", dig_q.size()); end
    if (rec_data.size() > 0) begin
      n_tests += 2;
      if (rec_idx[0] !== 64'd1) begin n_fail++; $display("FAIL abc_idx: got %0d want 1", rec_idx[0]); end
      if (rec_data[0] !== exp)  begin n_fail++; $display("FAIL abc_blk: got %h want %h", rec_data[0], exp); end
    end
    if (dig_q.size() > 0) begin
      n_tests++;
      if (dig_q[0] !== DIG_ABC) begin n_fail++; $display("FAIL abc_hash: got %h want %h", dig_q[0], DIG_ABC); end
    end
    n_tests += 2;
    if (hash !== DIG_ABC) begin n_fail++; $display("FAIL abc_hash_hold: got %h want %h", hash, DIG_ABC); end
    if (busy !== 1'b0)    begin n_fail++; $display("FAIL abc_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_two_block();
    logic [511:0] exp[$];
    clear_logs();
    model_blocks(str2q(STR_56), exp);
    send_msg(str2q(STR_56), 0, 0);
    wait_digest(1);
    n_tests++;
    if (rec_data.size() != 2) begin n_fail++; $display("FAIL b56_nblk: got %0d want 2", rec_data.size()); end
    for (int i = 0; i < rec_data.size() && i < 2; i++) begin
      n_tests += 2;
      if (rec_idx[i] !== 64'(i + 1)) begin n_fail++; $display("FAIL b56_idx%0d: got %0d want %0d", i, rec_idx[i], i + 1); end
      if (rec_data[i] !== exp[i])    begin n_fail++; $display("FAIL b56_blk%0d: got %h want %h", i, rec_data[i], exp[i]); end
    end
    if (rec_data.size() > 1) begin
      n_tests++;
      if (rec_data[1][511:480] !== 32'h1C0) begin n_fail++; $display("FAIL b56_len: got %h want 1c0", rec_data[1][511:480]); end
    end
    if (dig_q.size() > 0) begin
      n_tests++;
      if (dig_q[0] !== DIG_56) begin n_fail++; $display("FAIL b56_hash: got %h want %h", dig_q[0], DIG_56); end
    end
  endtask

  task automatic test_full_block();
    bq_t m;
    logic [511:0] exp[$];
    logic [511:0] blk2;
    m = rand_msg(64);
    model_blocks(m, exp);
    clear_logs();
    send_msg(m, 20, 0);
    wait_digest(1);
    repeat (20) @(negedge clk);
    blk2 = '0;
    blk2[31:0]    = 32'h80000000;
    blk2[511:480] = 32'h00000200;
    n_tests += 2;
    if (rec_data.size() != 2) begin n_fail++; $display("FAIL b64_nblk: got %0d want 2", rec_data.size()); end
    if (dig_q.size() != 1)    begin n_fail++; $display("FAIL b64_npulse: got %0d want 1", dig_q.size()); end
    if (rec_data.size() == 2) begin
      n_tests += 3;
      if (rec_data[0] !== exp[0]) begin n_fail++; $display("FAIL b64_blk0: got %h want %h", rec_data[0], exp[0]); end
      if (rec_data[1] !== blk2)   begin n_fail++; $display("FAIL b64_blk1: got %h want %h", rec_data[1], blk2); end
      if (rec_idx[1] !== 64'd2)   begin n_fail++; $display("FAIL b64_idx1: got %0d want 2", rec_idx[1]); end
    end
    if (dig_q.size() > 0) begin
      n_tests++;
      if (dig_q[0] !== model_digest(exp)) begin n_fail++; $display("FAIL b64_hash: got %h want %h", dig_q[0], model_digest(exp)); end
    end
  endtask

  task automatic test_len55();
    bq_t m;
    logic [511:0] exp[$];
    m = rand_msg(55);
    model_blocks(m, exp);
    clear_logs();
    send_msg(m, 0, 0);
    wait_digest(1);
    n_tests++;
    if (rec_data.size() != 1) begin n_fail++; $display("FAIL b55_nblk: got %0d want 1", rec_data.size()); end
    if (rec_data.size() > 0) begin
      n_tests += 4;
      if (rec_data[0][13*32 +: 8] !== 8'h80) begin n_fail++; $display("FAIL b55_pad: got %h want 80", rec_data[0][13*32 +: 8]); end
      if (rec_data[0][14*32 +: 32] !== 32'd0) begin n_fail++; $display("FAIL b55_w14: got %h want 0", rec_data[0][14*32 +: 32]); end
      if (rec_data[0][15*32 +: 32] !== 32'h1B8) begin n_fail++; $display("FAIL b55_w15: got %h want 1b8", rec_data[0][15*32 +: 32]); end
      if (rec_data[0] !== exp[0]) begin n_fail++; $display("FAIL b55_blk: got %h want %h", rec_data[0], exp[0]); end
    end
    if (dig_q.size() > 0) begin
      n_tests++;
      if (dig_q[0] !== model_digest(exp)) begin n_fail++; $display("FAIL b55_hash: got %h want %h", dig_q[0], model_digest(exp)); end
    end
  endtask

  // Second message is offered while the first is still padding/in the core.
  task automatic test_back_to_back();
    logic [63:0] exp_idx [3];
    exp_idx[0] = 64'd1; exp_idx[1] = 64'd2; exp_idx[2] = 64'd1;
    clear_logs();
    send_msg(str2q(STR_56), 40, 1);
    send_msg(str2q("abc"), 30, 0);
    wait_digest(2);
    n_tests += 2;
    if (rec_data.size() != 3) begin n_fail++; $display("FAIL b2b_nblk: got %0d want 3", rec_data.size()); end
    if (dig_q.size() != 2)    begin n_fail++; $display("FAIL b2b_npulse: got %0d want 2", dig_q.size()); end
    for (int i = 0; i < rec_idx.size() && i < 3; i++) begin
      n_tests++;
      if (rec_idx[i] !== exp_idx[i]) begin n_fail++; $display("FAIL b2b_idx%0d: got %0d want %0d", i, rec_idx[i], exp_idx[i]); end
    end
    if (dig_q.size() == 2) begin
      n_tests += 2;
      if (dig_q[0] !== DIG_56)  begin n_fail++; $display("FAIL b2b_hash0: got %h want %h", dig_q[0], DIG_56); end
      if (dig_q[1] !== DIG_ABC) begin n_fail++; $display("FAIL b2b_hash1: got %h want %h", dig_q[1], DIG_ABC); end
    end
  endtask

  task automatic test_reset_midwait();
    int c;
    bit en_seen;
    clear_logs();
    send_msg(str2q("abc"), 0, 0);
    c = 0;
    while (!blk_enable && c < 200) begin
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (!blk_enable) begin n_fail++; $display("FAIL rmw_no_send: blk_enable never rose in %0d cycles", c); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests += 7;
    if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL rmw_in_ready: got %b want 0", in_ready); end
    if (blk_enable !== 1'b0) begin n_fail++; $display("FAIL rmw_blk_enable: got %b want 0", blk_enable); end
    if (blk_data !== 512'd0) begin n_fail++; $display("FAIL rmw_blk_data: got %h want 0", blk_data); end
    if (blk_index !== 64'd0) begin n_fail++; $display("FAIL rmw_blk_index: got %h want 0", blk_index); end
    if (hash !== 160'd0)     begin n_fail++; $display("FAIL rmw_hash: got %h want 0", hash); end
    if (hash_valid !== 1'b0) begin n_fail++; $display("FAIL rmw_hash_valid: got %b want 0", hash_valid); end
    if (busy !== 1'b0)       begin n_fail++; $display("FAIL rmw_busy: got %b want 0", busy); end
    en_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (blk_enable) en_seen = 1;
    end
    n_tests++;
    if (en_seen) begin n_fail++; $display("FAIL rmw_enable_in_rst: got 1 want 0"); end
    rst = 1'b1;
    @(negedge clk);
    clear_logs();
    send_msg(str2q("abc"), 10, 0);
    wait_digest(1);
    n_tests += 2;
    if (rec_idx.size() != 1 || rec_idx[0] !== 64'd1) begin
      n_fail++; $display("FAIL rmw_idx: got %0d blocks, first index %0d, want 1 block index 1", rec_idx.size(), (rec_idx.size() > 0) ? rec_idx[0] : 64'd0);
    end
    if (dig_q.size() != 1 || dig_q[0] !== DIG_ABC) begin
      n_fail++; $display("FAIL rmw_hash: got %0d digests, first %h, want %h", dig_q.size(), (dig_q.size() > 0) ? dig_q[0] : 160'd0, DIG_ABC);
    end
  endtask

  task automatic test_random();
    int lens [14];
    bq_t m;
    logic [511:0] exp[$];
    lens = '{1, 4, 51, 52, 53, 56, 57, 60, 63, 65, 119, 120, 128, 0};
    lens[13] = $urandom_range(200, 2);
    for (int t = 0; t < 14; t++) begin
      m = rand_msg(lens[t]);
      model_blocks(m, exp);
      clear_logs();
      send_msg(m, $urandom_range(50), 0);
      wait_digest(1);
      n_tests++;
      if (rec_data.size() != exp.size()) begin
        n_fail++; $display("FAIL rnd_nblk len=%0d: got %0d want %0d", lens[t], rec_data.size(), exp.size());
      end
      for (int i = 0; i < rec_data.size() && i < exp.size(); i++) begin
        n_tests += 2;
        if (rec_idx[i] !== 64'(i + 1)) begin n_fail++; $display("FAIL rnd_idx len=%0d blk=%0d: got %0d want %0d", lens[t], i, rec_idx[i], i + 1); end
        if (rec_data[i] !== exp[i])    begin n_fail++; $display("FAIL rnd_blk len=%0d blk=%0d: got %h want %h", lens[t], i, rec_data[i], exp[i]); end
      end
      if (dig_q.size() > 0) begin
        n_tests++;
        if (dig_q[0] !== model_digest(exp)) begin
          n_fail++; $display("FAIL rnd_hash len=%0d: got %h want %h", lens[t], dig_q[0], model_digest(exp));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_two_block();
    test_full_block();
    test_len55();
    test_back_to_back();
    test_reset_midwait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
